// File: rtl/apu_pkg.sv
// APU shared types and constants for the channel 1 sweep unit.
// Optional feature macro: CH1_SWEEP_NEGATE_QUIRK_EN (used by ch1_sweep_ctrl).
package apu_pkg;

  localparam int FREQ_W = 11;
  localparam int FREQ_MAX = 2047;
  localparam int SWEEP_PERIOD_ZERO_RELOAD = 8;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    UPDATE,
    RECHECK
  } sweep_state_t;

endpackage

// File: rtl/ch1_sweep_calc.sv
// Channel 1 sweep arithmetic: shift, add/sub and overflow detect.
// Purely combinational; one instance is shared by every FSM state.
module ch1_sweep_calc
  import apu_pkg::*;
(
  input  logic [FREQ_W-1:0] shadow_i,
  input  logic [2:0]        shift_i,
  input  logic              negate_i,
  output logic [FREQ_W-1:0] freq_o,
  output logic              ovf_o
);

  localparam logic [FREQ_W:0] FMAX = FREQ_MAX[FREQ_W:0];

  logic [FREQ_W:0] delta;
  logic [FREQ_W:0] sum;

  assign delta = {1'b0, shadow_i >> shift_i};
  // delta <= shadow, so the subtract path can never exceed FMAX
  assign sum = negate_i ? ({1'b0, shadow_i} - delta)
                        : ({1'b0, shadow_i} + delta);
  assign freq_o = sum[FREQ_W-1:0];
  assign ovf_o  = sum > FMAX;

endmodule

// File: rtl/ch1_sweep_ctrl.sv
// Channel 1 frequency sweep controller (trigger check, tick update, recheck).
// Optional: CH1_SWEEP_NEGATE_QUIRK_EN disables the channel on negate 1->0.
module ch1_sweep_ctrl
  import apu_pkg::*;
(
  input  logic              clk,
  input  logic              apu_reset,
  input  logic              sweep_tick,
  input  logic              ch1_restart,
  input  logic [2:0]        sweep_period,
  input  logic              sweep_negate,
  input  logic [2:0]        sweep_shift,
  input  logic [FREQ_W-1:0] freq_in,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_load,
  output logic              ch1_disable,
  output logic              sweep_busy
);

  sweep_state_t      state_q, state_d;
  logic [FREQ_W-1:0] shadow_q, shadow_d;
  logic [2:0]        timer_q, timer_d;
  logic              sweep_en_q, sweep_en_d;
  logic [FREQ_W-1:0] fout_q, fout_d;
  logic              load_q, load_d;
  logic              dis_q, dis_d;
`ifdef CH1_SWEEP_NEGATE_QUIRK_EN
  logic              neg_used_q, neg_used_d;
  logic              negate_q;
`endif

  logic [FREQ_W-1:0] calc_freq;
  logic              calc_ovf;
  logic [2:0]        reload;

  ch1_sweep_calc u_calc (
    .shadow_i (shadow_q),
    .shift_i  (sweep_shift),
    .negate_i (sweep_negate),
    .freq_o   (calc_freq),
    .ovf_o    (calc_ovf)
  );

  // Reload of 8 wraps to 0 in the 3-bit timer, which still spans 8 ticks
  assign reload = (sweep_period == 3'd0) ?
                  3'(SWEEP_PERIOD_ZERO_RELOAD) : sweep_period;

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    timer_d    = timer_q;
    sweep_en_d = sweep_en_q;
    fout_d     = fout_q;
    load_d     = 1'b0;
    dis_d      = 1'b0;
`ifdef CH1_SWEEP_NEGATE_QUIRK_EN
    neg_used_d = neg_used_q;
`endif
    if (ch1_restart) begin
      shadow_d   = freq_in;
      timer_d    = reload;
      sweep_en_d = (sweep_period != 3'd0) || (sweep_shift != 3'd0);
`ifdef CH1_SWEEP_NEGATE_QUIRK_EN
      neg_used_d = 1'b0;
`endif
      state_d    = (sweep_shift != 3'd0) ? CHECK : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sweep_tick) begin
            timer_d = timer_q - 3'd1;
            if (timer_d == 3'd0) begin
              timer_d = reload;
              if (sweep_en_q && sweep_period != 3'd0)
                state_d = UPDATE;
            end
          end
        end
        CHECK, RECHECK: begin
          state_d = IDLE;
          if (calc_ovf) begin
            dis_d      = 1'b1;
            sweep_en_d = 1'b0;
          end
        end
        UPDATE: begin
          state_d = IDLE;
          if (calc_ovf) begin
            dis_d      = 1'b1;
            sweep_en_d = 1'b0;
          end else if (sweep_shift != 3'd0) begin
            shadow_d = calc_freq;
            fout_d   = calc_freq;
            load_d   = 1'b1;
            state_d  = RECHECK;
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef CH1_SWEEP_NEGATE_QUIRK_EN
      if (state_q != IDLE && sweep_negate)
        neg_used_d = 1'b1;
      if (negate_q && !sweep_negate && neg_used_q && sweep_en_q) begin
        dis_d      = 1'b1;
        sweep_en_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (apu_reset) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      timer_q    <= '0;
      sweep_en_q <= 1'b0;
      fout_q     <= '0;
      load_q     <= 1'b0;
      dis_q      <= 1'b0;
`ifdef CH1_SWEEP_NEGATE_QUIRK_EN
      neg_used_q <= 1'b0;
      negate_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      timer_q    <= timer_d;
      sweep_en_q <= sweep_en_d;
      fout_q     <= fout_d;
      load_q     <= load_d;
      dis_q      <= dis_d;
`ifdef CH1_SWEEP_NEGATE_QUIRK_EN
      neg_used_q <= neg_used_d;
      negate_q   <= sweep_negate;
`endif
    end
  end

  assign freq_out    = fout_q;
  assign freq_load   = load_q;
  assign ch1_disable = dis_q;
  assign sweep_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ch1_sweep_ctrl.sv
// Directed bench for ch1_sweep_ctrl with an event scoreboard.
// Strobe events are queued with their expected edge index and popped on output.
module tb_ch1_sweep_ctrl;

  logic        clk = 1'b0;
  logic        apu_reset = 1'b1;
  logic        sweep_tick = 1'b0;
  logic        ch1_restart = 1'b0;
  logic [2:0]  sweep_period = 3'd0;
  logic        sweep_negate = 1'b0;
  logic [2:0]  sweep_shift = 3'd0;
  logic [10:0] freq_in = 11'd0;
  logic [10:0] freq_out;
  logic        freq_load;
  logic        ch1_disable;
  logic        sweep_busy;

  typedef struct {
    int          cyc;
    logic        load;
    logic [10:0] freq;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  s;

  ch1_sweep_ctrl dut (
    .clk          (clk),
    .apu_reset    (apu_reset),
    .sweep_tick   (sweep_tick),
    .ch1_restart  (ch1_restart),
    .sweep_period (sweep_period),
    .sweep_negate (sweep_negate),
    .sweep_shift  (sweep_shift),
    .freq_in      (freq_in),
    .freq_out     (freq_out),
    .freq_load    (freq_load),
    .ch1_disable  (ch1_disable),
    .sweep_busy   (sweep_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ev(logic load, logic [10:0] f);
    ev_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL unexpected_strobe observed load=%0b cyc=%0d expected none",
             load, cyc);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert ({cyc, load, f} === {e.cyc, e.load, e.freq}) else begin
        errors++;
        $error("FAIL strobe observed cyc=%0d load=%0b f=%0h expected cyc=%0d load=%0b f=%0h",
               cyc, load, f, e.cyc, e.load, e.freq);
      end
    end
  endtask

  always @(negedge clk) begin
    if (freq_load)   chk_ev(1'b1, freq_out);
    if (ch1_disable) chk_ev(1'b0, 11'd0);
  end

  task automatic push(int c, logic load, logic [10:0] f);
    ev_t e;
    e.cyc = c; e.load = load; e.freq = f;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic tick();
    sweep_tick = 1'b1; step(); sweep_tick = 1'b0;
  endtask

  task automatic trigger(logic [10:0] f, logic [2:0] per,
                         logic neg, logic [2:0] sh);
    freq_in = f; sweep_period = per;
    sweep_negate = neg; sweep_shift = sh;
    ch1_restart = 1'b1; step(); ch1_restart = 1'b0;
  endtask

  initial begin
    idle(2);
    check("rst_freq_out", 32'(freq_out), 32'h0);
    check("rst_freq_load", 32'(freq_load), 32'h0);
    check("rst_disable", 32'(ch1_disable), 32'h0);
    check("rst_busy", 32'(sweep_busy), 32'h0);
    apu_reset = 1'b0;
    idle(2);

    // add sweep: update to 0x600, recheck 0x900 overflows
    trigger(11'h400, 3'd1, 1'b0, 3'd1);
    check("busy_in_check", 32'(sweep_busy), 32'h1);
    idle(3);
    check("busy_back_idle", 32'(sweep_busy), 32'h0);
    s = cyc + 1;
    push(s + 1, 1'b1, 11'h600);
    push(s + 2, 1'b0, 11'h0);
    tick();
    idle(4);

    // trigger-time overflow check
    s = cyc + 1;
    push(s + 1, 1'b0, 11'h0);
    trigger(11'h7FF, 3'd0, 1'b0, 3'd1);
    idle(4);

    // shift 0 add still overflows (2 * 0x500)
    trigger(11'h500, 3'd1, 1'b0, 3'd0);
    check("shift0_no_check", 32'(sweep_busy), 32'h0);
    s = cyc + 1;
    push(s + 1, 1'b0, 11'h0);
    tick();
    idle(4);

    // period 0: check once, ticks never update
    trigger(11'h100, 3'd0, 1'b0, 3'd2);
    check("p0_busy_check", 32'(sweep_busy), 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      idle(2);
    end
    check("p0_busy_end", 32'(sweep_busy), 32'h0);

    // subtract, period 3: one load of 0x0C0 on the 3rd tick
    trigger(11'h100, 3'd3, 1'b1, 3'd2);
    idle(3);
    tick(); idle(3);
    tick(); idle(3);
    s = cyc + 1;
    push(s + 1, 1'b1, 11'h0C0);
    tick();
    idle(4);

    // trigger and tick together; later freq_in change ignored
    freq_in = 11'h100; sweep_period = 3'd2;
    sweep_negate = 1'b0; sweep_shift = 3'd1;
    ch1_restart = 1'b1; sweep_tick = 1'b1;
    step();
    ch1_restart = 1'b0; sweep_tick = 1'b0;
    freq_in = 11'h7FF;
    idle(3);
    tick(); idle(3);
    s = cyc + 1;
    push(s + 1, 1'b1, 11'h180);
    tick();
    idle(4);

    // trigger during RECHECK aborts its pending disable
    trigger(11'h400, 3'd1, 1'b0, 3'd1);
    idle(3);
    s = cyc + 1;
    push(s + 1, 1'b1, 11'h600);
    tick();
    step();
    check("busy_in_recheck", 32'(sweep_busy), 32'h1);
    trigger(11'h100, 3'd1, 1'b0, 3'd1);
    check("busy_after_abort", 32'(sweep_busy), 32'h1);
    idle(3);
    s = cyc + 1;
    push(s + 1, 1'b1, 11'h180);
    tick();
    idle(4);

    // reset while a disable is pending
    trigger(11'h7FF, 3'd0, 1'b0, 3'd1);
    apu_reset = 1'b1;
    step();
    apu_reset = 1'b0;
    check("midrst_disable", 32'(ch1_disable), 32'h0);
    check("midrst_freq_out", 32'(freq_out), 32'h0);
    check("midrst_busy", 32'(sweep_busy), 32'h0);
    idle(3);

    // negate 1->0 after a negate calc
    trigger(11'h100, 3'd0, 1'b1, 3'd1);
    idle(3);
`ifdef CH1_SWEEP_NEGATE_QUIRK_EN
    push(cyc + 1, 1'b0, 11'h0);
`endif
    sweep_negate = 1'b0;
    step();
    idle(4);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ch1_sweep_ctrl.md
CH1_SWEEP_CTRL -- requirements
Module: ch1_sweep_ctrl

Interface
REQ-001 clk  in  1  APU system clock; all state updates on rising edge.
REQ-002 apu_reset  in  1  reset, synchronous, active-high.
REQ-003 sweep_tick  in  1  one-cycle 128 Hz enable from the frame sequencer.
REQ-004 ch1_restart  in  1  one-cycle trigger pulse for channel 1 (NR14 bit 7 write).
REQ-005 sweep_period  in  3  NR10[6:4].
REQ-006 sweep_negate  in  1  NR10[3]; 1 = subtract.
REQ-007 sweep_shift  in  3  NR10[2:0].
REQ-008 freq_in  in  11  current NR13/NR14 frequency.
REQ-009 freq_out  out  11  new frequency for the channel 1 frequency counter.
REQ-010 freq_load  out  1  one-cycle strobe; counter loads freq_out.
REQ-011 ch1_disable  out  1  one-cycle strobe; channel 1 turns off.
REQ-012 sweep_busy  out  1  high while the FSM is outside IDLE.

Function
REQ-013 Block SHALL hold shadow[10:0], timer[2:0], sweep_en, neg_used.
REQ-014 FSM states SHALL be IDLE, CHECK, UPDATE, RECHECK; each non-IDLE state lasts exactly one cycle.
REQ-015 Calc SHALL be delta = shadow >> sweep_shift, then new = shadow - delta if negate, else shadow + delta, in 12 bits; overflow = new > 2047.
REQ-016 On ch1_restart: shadow <= freq_in; timer <= period (0 reloads as 8); sweep_en <= (period != 0) || (shift != 0); neg_used <= 0; next state CHECK if shift != 0, else IDLE.
REQ-017 CHECK SHALL compute only; overflow -> ch1_disable pulse and sweep_en <= 0; go IDLE.
REQ-018 On sweep_tick in IDLE: timer decrements; on reaching 0 it reloads (period 0 -> 8); the FSM goes to UPDATE only if sweep_en && period != 0.
REQ-019 UPDATE: overflow -> ch1_disable and sweep_en <= 0, go IDLE; else if shift != 0: shadow <= new, freq_out <= new, freq_load pulse, go RECHECK; else go IDLE.
REQ-020 RECHECK SHALL recompute with the updated shadow; overflow -> ch1_disable and sweep_en <= 0; no write-back; go IDLE.
REQ-021 Any calc in a state with negate = 1 SHALL set neg_used.
REQ-022 ch1_restart SHALL have priority over sweep_tick in the same cycle and SHALL abort any in-progress state, restarting per REQ-016.
REQ-023 A sweep_tick while sweep_busy SHALL be ignored, including the timer decrement.
REQ-024 freq_in changes after a trigger SHALL NOT alter shadow.
REQ-025 Subtraction SHALL never overflow; shift = 0 with add SHALL still overflow-check (2*shadow).

Reset
REQ-026 On apu_reset: state IDLE, shadow 0, timer 0, sweep_en 0, neg_used 0, freq_out 0, freq_load 0, ch1_disable 0, sweep_busy 0.
REQ-027 Reset mid-operation SHALL suppress any pending strobe in that cycle.

Configuration
REQ-028 Macro CH1_SWEEP_NEGATE_QUIRK_EN: when defined, sweep_negate 1->0 while neg_used && sweep_en SHALL pulse ch1_disable and clear sweep_en.
REQ-029 When the macro is undefined, negate changes SHALL have no side effect and neg_used SHALL be omitted.

Structure
REQ-030 Package apu_pkg SHALL hold the sweep_state_t enum, FREQ_W = 11, FREQ_MAX = 2047 and SWEEP_PERIOD_ZERO_RELOAD = 8.
REQ-031 Sub-module ch1_sweep_calc SHALL hold the combinational shift/add/sub and overflow logic, instanced once and shared by all states.

Verification
REQ-032 freq_in = 0x400, shift = 1, add, period = 1; trigger, then tick -> freq_load with freq_out = 0x600 in UPDATE; RECHECK 0x900 overflows -> ch1_disable one cycle later.
REQ-033 freq_in = 0x7FF, shift = 1, add; trigger -> ch1_disable two cycles after the trigger; no freq_load.
REQ-034 period = 0, shift = 2; trigger, then 20 ticks -> CHECK runs once; no UPDATE, no freq_load.
REQ-035 period = 3, freq_in = 0x100, shift = 2, sub; trigger, then 3 ticks -> exactly one freq_load, freq_out = 0x0C0.
REQ-036 Trigger and tick in the same cycle, and trigger during RECHECK -> shadow reloads, timer = period, no stale strobe.
REQ-037 With the quirk macro defined: negate = 1, trigger, shift = 1, then clear negate -> ch1_disable next cycle; with the macro undefined -> no disable.
